register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   General-purpose register file for the 19-bit pipelined processor core.
//   Two combinational read ports serve the decode stage (source operands Rf1/Rf2).
//   One synchronous write port is driven by the writeback stage (Rd, RegWriteW, ResultW).
//   Register 0 is hardwired to zero.
// PARAMETERS
//   DATA_WIDTH  19  width of each register and of wd3/rd1/rd2
//   ADDR_WIDTH  5   width of a1/a2/a3
//   NUM_REGS    32  register count; must equal 2**ADDR_WIDTH
// PORTS
//   clk    in   1           single clock; all state updates on rising edge
//   reset  in   1           synchronous, active-high; clears all registers
//   a1     in   ADDR_WIDTH  read port 1 address (Rf1)
//   a2     in   ADDR_WIDTH  read port 2 address (Rf2)
//   a3     in   ADDR_WIDTH  write address (Rd)
//   we3    in   1           write enable from writeback (RegWriteW)
//   wd3    in   DATA_WIDTH  write data from writeback (ResultW)
//   rd1    out  DATA_WIDTH  read data for a1
//   rd2    out  DATA_WIDTH  read data for a2
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous and active-high.
//   - Storage: NUM_REGS x DATA_WIDTH flops, regs[0..NUM_REGS-1].
//   - Reset: while reset=1 at a rising clk edge, all regs become 0.
//     Reset takes priority over a simultaneous write.
//     Outputs read 0 from the first edge after reset is asserted.
//     Before the first reset, contents are undefined (X in sim).
//   - Write: at a rising edge with reset=0, we3=1 and a3!=0, regs[a3] <= wd3.
//     we3=0 leaves all state unchanged.
//     A write to a3=0 is discarded; regs[0] stays 0.
//   - Read: rd1/rd2 are combinational with zero-cycle latency. There is no read enable.
//     If aN=0, rdN=0 regardless of storage contents.
//     Otherwise rdN = regs[aN], subject to bypass.
//   - Write-to-read bypass:
//     If we3=1, a3!=0, aN==a3 and reset=0, then rdN = wd3 in the same cycle.
//     This lets a decode-stage read see the writeback value without a hazard stall.
//     The bypass applies independently to both ports.
//   - Both ports may address the same register, or the write register, at once.
//     Each port resolves independently by the rules above.
//   - No arithmetic; data is stored and returned unmodified at DATA_WIDTH bits.
//   - Unknown (X) addresses must not corrupt other registers; only regs[a3] may change.
// TESTING
//   - Reset clear:
//     write regs[1..31] with nonzero values, assert reset for one edge,
//     then sweep a1/a2 over 0..31 -> rd1=rd2=0 everywhere.
//   - Basic write/read:
//     reset=0, we3=1, a3=2, wd3=19'h4, one edge, then we3=0, a1=a2=2 -> rd1=rd2=19'h4.
//     Next cycle: a1=a2=5 -> rd1=rd2=0.
//   - Bypass:
//     we3=1, a3=7, wd3=19'h7FFFF, a1=7, a2=3 before the edge ->
//     rd1=19'h7FFFF combinationally; rd2=regs[3].
//     After the edge, with we3=0, rd1 is still 19'h7FFFF.
//   - Write disable:
//     we3=0, a3=2, wd3=19'h1234, one edge -> a1=2 still reads 19'h4.
//   - Register 0:
//     we3=1, a3=0, wd3=19'h55, one edge -> a1=0 reads 0, including during the write cycle.
//   - Reset vs write:
//     reset=1 and we3=1, a3=9, wd3=19'hABC on the same edge ->
//     after the edge, rd1 for a1=9 reads 0.
//   - Randomized:
//     random a1/a2/a3/we3/wd3 for 10k cycles compared against a reference model
//     with the bypass and r0 rules above.

Source files
------------

// File: rtl/register_file.sv
// 32 x 19-bit general-purpose register file: two combinational read ports with
// write-to-read bypass, one synchronous write port, register 0 reads as zero.
module register_file #(
   parameter int DATA_WIDTH = 19,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] a1,
   input  logic [ADDR_WIDTH-1:0] a2,
   input  logic [ADDR_WIDTH-1:0] a3,
   input  logic                  we3,
   input  logic [DATA_WIDTH-1:0] wd3,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2
);

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic                  wr_active_s;
   logic                  byp1_s;
   logic                  byp2_s;

   // A write is live only when enabled, aimed at a real register and not overridden by reset.
   assign wr_active_s = we3 && (a3 != {ADDR_WIDTH{1'b0}}) && !reset;
   assign byp1_s      = wr_active_s && (a1 == a3);
   assign byp2_s      = wr_active_s && (a2 == a3);

   // Storage update; per-register compare keeps an unknown a3 from touching any entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (we3 && (a3 == ADDR_WIDTH'(i))) begin
               regs_r[i] <= wd3;
            end
         end
      end
   end

   // Read port 1: zero register, then bypass, then storage.
   always_comb begin
      rd1 = {DATA_WIDTH{1'b0}};
      if (a1 == {ADDR_WIDTH{1'b0}}) begin
         rd1 = {DATA_WIDTH{1'b0}};
      end else if (byp1_s) begin
         rd1 = wd3;
      end else begin
         rd1 = regs_r[a1];
      end
   end

   // Read port 2: same resolution as port 1, independently.
   always_comb begin
      rd2 = {DATA_WIDTH{1'b0}};
      if (a2 == {ADDR_WIDTH{1'b0}}) begin
         rd2 = {DATA_WIDTH{1'b0}};
      end else if (byp2_s) begin
         rd2 = wd3;
      end else begin
         rd2 = regs_r[a2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors with hand-computed
// expectations followed by a randomized run against a small reference model.
module tb_register_file;

   localparam int DW = 19;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] a1, a2, a3;
   logic          we3;
   logic [DW-1:0] wd3;
   logic [DW-1:0] rd1, rd2;

   logic [DW-1:0] model [32];
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .a1    (a1),
      .a2    (a2),
      .a3    (a3),
      .we3   (we3),
      .wd3   (wd3),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 19'h%05h, expected 19'h%05h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference read: zero register, bypass of a live write, else stored value.
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (a == 5'd0) return 19'h0;
      if (!reset && we3 && (a3 != 5'd0) && (a == a3)) return wd3;
      return model[a];
   endfunction

   // Apply the effect of the coming edge to the model.
   task automatic commit();
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 19'h0;
      end else if (we3 && (a3 != 5'd0)) begin
         model[a3] = wd3;
      end
   endtask

   initial begin
      reset = 1'b1; we3 = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; wd3 = 19'h0;
      commit();
      tick();
      reset = 1'b0;
      a1 = 5'd0; a2 = 5'd5; #1;
      check_eq("init_rst_rd1_r0", rd1, 19'h0);
      check_eq("init_rst_rd2_r5", rd2, 19'h0);

      // Fill regs 1..31 with nonzero values and read them back.
      we3 = 1'b1;
      for (int i = 1; i < 32; i++) begin
         a3  = AW'(i);
         wd3 = DW'(i * 32'h2345 + 32'd1);
         commit();
         tick();
      end
      we3 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         a1 = AW'(i); a2 = AW'(31 - i); #1;
         check_eq("fill_rd1", rd1, exp_rd(a1));
         check_eq("fill_rd2", rd2, exp_rd(a2));
      end

      // Reset clear: one reset edge, then everything reads zero.
      reset = 1'b1;
      commit();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         a1 = AW'(i); a2 = AW'(31 - i); #1;
         check_eq("rst_clear_rd1", rd1, 19'h0);
         check_eq("rst_clear_rd2", rd2, 19'h0);
      end

      // Basic write/read.
      we3 = 1'b1; a3 = 5'd2; wd3 = 19'h4;
      commit(); tick();
      we3 = 1'b0; a1 = 5'd2; a2 = 5'd2; #1;
      check_eq("basic_rd1", rd1, 19'h4);
      check_eq("basic_rd2", rd2, 19'h4);
      tick();
      a1 = 5'd5; a2 = 5'd5; #1;
      check_eq("basic_unwritten_rd1", rd1, 19'h0);
      check_eq("basic_unwritten_rd2", rd2, 19'h0);

      // Bypass: write value visible combinationally before the edge.
      we3 = 1'b1; a3 = 5'd7; wd3 = 19'h7FFFF; a1 = 5'd7; a2 = 5'd3; #1;
      check_eq("bypass_rd1", rd1, 19'h7FFFF);
      check_eq("bypass_rd2_other", rd2, 19'h0);
      commit(); tick();
      we3 = 1'b0; #1;
      check_eq("bypass_after_edge", rd1, 19'h7FFFF);

      // Write disable.
      we3 = 1'b0; a3 = 5'd2; wd3 = 19'h1234; a1 = 5'd2; #1;
      check_eq("wdis_no_bypass", rd1, 19'h4);
      commit(); tick();
      check_eq("wdis_after_edge", rd1, 19'h4);

      // Register 0 write is discarded, including during the write cycle.
      we3 = 1'b1; a3 = 5'd0; wd3 = 19'h55; a1 = 5'd0; a2 = 5'd0; #1;
      check_eq("r0_during_write", rd1, 19'h0);
      check_eq("r0_during_write_p2", rd2, 19'h0);
      commit(); tick();
      we3 = 1'b0; #1;
      check_eq("r0_after_write", rd1, 19'h0);

      // Reset beats a simultaneous write, and suppresses bypass.
      reset = 1'b1; we3 = 1'b1; a3 = 5'd9; wd3 = 19'hABC; a1 = 5'd9; a2 = 5'd2; #1;
      check_eq("rstwr_no_bypass", rd1, 19'h0);
      check_eq("rstwr_old_value", rd2, 19'h4);
      commit(); tick();
      reset = 1'b0; we3 = 1'b0; #1;
      check_eq("rstwr_rd1", rd1, 19'h0);
      check_eq("rstwr_rd2", rd2, 19'h0);

      // Randomized run against the reference model.
      for (int n = 0; n < 10000; n++) begin
         reset = ($urandom_range(0, 127) == 0);
         we3   = ($urandom_range(0, 3) != 0);
         a3    = AW'($urandom_range(0, 31));
         wd3   = DW'($urandom);
         a1    = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, 31));
         a2    = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, 31));
         #1;
         check_eq("rand_rd1", rd1, exp_rd(a1));
         check_eq("rand_rd2", rd2, exp_rd(a2));
         commit();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
